// File: rtl/grover_iter_ctrl.sv
// -----------------------------------------------------------------------------
// grover_iter_ctrl
//
// Sequencer for a complete Grover search over NUM_SAMPLE = 2^NUM_BIT signed
// Q1.6 amplitudes kept in an internal register file. A start request sets up a
// uniform superposition. The block then runs num_iter iterations. Each
// iteration is an oracle phase flip of the target amplitude followed by
// diffusion (inversion about the mean). A one-cycle done pulse marks the end of
// the run.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, only honoured in IDLE
//   target    in   marked index, latched when start is accepted
//   num_iter  in   iteration count, latched when start is accepted
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse in the DONE state
//   iter_cnt  out  number of completed iterations
//   rd_addr   in   read index
//   rd_data   out  amp[rd_addr], combinational
// -----------------------------------------------------------------------------
module grover_iter_ctrl #(
  parameter int unsigned NUM_BIT  = 3,
  parameter int unsigned AMP_W    = 8,
  parameter int unsigned ITER_W   = 4,
  parameter int          INIT_AMP = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_BIT-1:0]      target,
  input  logic [ITER_W-1:0]       num_iter,
  output logic                    busy,
  output logic                    done,
  output logic [ITER_W-1:0]       iter_cnt,
  input  logic [NUM_BIT-1:0]      rd_addr,
  output logic signed [AMP_W-1:0] rd_data
);

  localparam int unsigned NUM_SAMPLE = 1 << NUM_BIT;
  // Wide enough to hold the sum of NUM_SAMPLE amplitudes without overflow.
  localparam int unsigned SUM_W      = AMP_W + NUM_BIT;
  // Two guard bits for 2*mean - amp and for negating the most negative value.
  localparam int unsigned EXT_W      = AMP_W + 2;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StInit  = 3'd1;
  localparam logic [2:0] StPhase = 3'd2;
  localparam logic [2:0] StSum   = 3'd3;
  localparam logic [2:0] StMean  = 3'd4;
  localparam logic [2:0] StDiff  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  // Clamp an EXT_W-bit signed value into the AMP_W-bit signed range. The value
  // fits when the top three bits (the sign and both guard bits) all agree.
  function automatic logic [AMP_W-1:0] sat(input logic [EXT_W-1:0] v);
    logic [2:0] top;
    top = v[EXT_W-1 -: 3];
    if (top == 3'b000 || top == 3'b111) begin
      sat = v[AMP_W-1:0];
    end else if (v[EXT_W-1]) begin
      sat = {1'b1, {(AMP_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(AMP_W-1){1'b1}}};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]              state_q, state_d;
  logic signed [AMP_W-1:0] amp_q [NUM_SAMPLE];
  logic signed [AMP_W-1:0] amp_d [NUM_SAMPLE];
  logic [NUM_BIT-1:0]      idx_q, idx_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [AMP_W-1:0] mean_q, mean_d;
  logic [ITER_W-1:0]       iter_cnt_q, iter_cnt_d;
  logic [NUM_BIT-1:0]      target_q, target_d;
  logic [ITER_W-1:0]       num_iter_q, num_iter_d;

  // Datapath temporaries
  logic [AMP_W-1:0]        cur_amp;
  logic [AMP_W-1:0]        tgt_amp;
  logic [EXT_W-1:0]        phase_val;
  logic [EXT_W-1:0]        diff_val;
  logic [ITER_W-1:0]       iter_next;

  always_comb begin
    cur_amp   = amp_q[idx_q];
    tgt_amp   = amp_q[target_q];
    // Negate in the extended width so that -(-128) becomes +128 before clamping.
    phase_val = -{{2{tgt_amp[AMP_W-1]}}, tgt_amp};
    // 2*mean - amp, computed without loss and then clamped.
    diff_val  = {mean_q[AMP_W-1], mean_q, 1'b0} - {{2{cur_amp[AMP_W-1]}}, cur_amp};
    iter_next = iter_cnt_q + ITER_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    amp_d      = amp_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    mean_d     = mean_q;
    iter_cnt_d = iter_cnt_q;
    target_d   = target_q;
    num_iter_d = num_iter_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          target_d   = target;
          num_iter_d = num_iter;
          state_d    = StInit;
        end
      end

      StInit: begin
        for (int i = 0; i < NUM_SAMPLE; i++) begin
          amp_d[i] = AMP_W'(INIT_AMP);
        end
        iter_cnt_d = '0;
        idx_d      = '0;
        state_d    = (num_iter_q == '0) ? StDone : StPhase;
      end

      StPhase: begin
        amp_d[target_q] = sat(phase_val);
        // The accumulator is cleared here because SUM is only entered from PHASE.
        sum_d           = '0;
        idx_d           = '0;
        state_d         = StSum;
      end

      StSum: begin
        sum_d = sum_q + {{NUM_BIT{cur_amp[AMP_W-1]}}, cur_amp};
        idx_d = idx_q + NUM_BIT'(1);
        if (idx_q == '1) begin
          state_d = StMean;
        end
      end

      StMean: begin
        // Arithmetic shift floors toward -inf. The result always fits in AMP_W
        // bits because it is the mean of AMP_W-bit values.
        mean_d  = AMP_W'(sum_q >>> NUM_BIT);
        idx_d   = '0;
        state_d = StDiff;
      end

      StDiff: begin
        amp_d[idx_q] = sat(diff_val);
        idx_d        = idx_q + NUM_BIT'(1);
        if (idx_q == '1) begin
          iter_cnt_d = iter_next;
          state_d    = (iter_next == num_iter_q) ? StDone : StPhase;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      sum_q      <= '0;
      mean_q     <= '0;
      iter_cnt_q <= '0;
      target_q   <= '0;
      num_iter_q <= '0;
      for (int i = 0; i < NUM_SAMPLE; i++) begin
        amp_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      iter_cnt_q <= iter_cnt_d;
      target_q   <= target_d;
      num_iter_q <= num_iter_d;
      for (int i = 0; i < NUM_SAMPLE; i++) begin
        amp_q[i] <= amp_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign iter_cnt = iter_cnt_q;
  assign rd_data  = amp_q[rd_addr];

endmodule

// File: tb/tb_grover_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grover_iter_ctrl
//
// Directed bench for grover_iter_ctrl. The default instance covers the normal
// runs. A second instance with INIT_AMP = -128 covers the saturation corners.
// Expected values are worked out by hand from the algorithm.
// -----------------------------------------------------------------------------
module tb_grover_iter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  // Default instance
  logic              start;
  logic [2:0]        target;
  logic [3:0]        num_iter;
  logic              busy;
  logic              done;
  logic [3:0]        iter_cnt;
  logic [2:0]        rd_addr;
  logic signed [7:0] rd_data;
  // INIT_AMP = -128 instance
  logic              start_m;
  logic [2:0]        target_m;
  logic [3:0]        num_iter_m;
  logic              busy_m;
  logic              done_m;
  logic [3:0]        iter_cnt_m;
  logic [2:0]        rd_addr_m;
  logic signed [7:0] rd_data_m;

  grover_iter_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .target   (target),
    .num_iter (num_iter),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  grover_iter_ctrl #(
    .INIT_AMP (-128)
  ) dut_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_m),
    .target   (target_m),
    .num_iter (num_iter_m),
    .busy     (busy_m),
    .done     (done_m),
    .iter_cnt (iter_cnt_m),
    .rd_addr  (rd_addr_m),
    .rd_data  (rd_data_m)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int cyc;
  int d0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Read every amplitude. Index 'hot' must read hot_val and all others other_val.
  task automatic check_amps(input bit m, input string tag, input int hot,
                            input int hot_val, input int other_val);
    for (int i = 0; i < 8; i++) begin
      if (m) rd_addr_m = 3'(i);
      else   rd_addr   = 3'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), m ? rd_data_m : rd_data,
          (i == hot) ? hot_val : other_val);
    end
  endtask

  // Launch a run and return the cycle index (1 = INIT) at which done is seen.
  // When inject > 0, a spurious start with different operands is pulsed then.
  task automatic run(input bit m, input int tgt, input int n, input int inject,
                     output int c);
    @(posedge clk); #1;
    if (m) begin
      start_m = 1'b1; target_m = 3'(tgt); num_iter_m = 4'(n);
    end else begin
      start = 1'b1; target = 3'(tgt); num_iter = 4'(n);
    end
    @(posedge clk); #1;
    start = 1'b0; start_m = 1'b0;
    c = 1;
    while (((m ? done_m : done) !== 1'b1) && c < 300) begin
      if (c == inject) begin
        start = 1'b1; target = 3'd3; num_iter = 4'd4;
      end
      @(posedge clk); #1;
      c++;
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; target = '0; num_iter = '0; rd_addr = '0;
    start_m = 1'b0; target_m = '0; num_iter_m = '0; rd_addr_m = '0;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_busy_m", busy_m, 0);
    check_amps(1'b0, "rst_amp", -1, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Scenario 1: zero iterations
    run(1'b0, 0, 0, 0, cyc);
    chk("s1_cyc", cyc, 2);
    chk("s1_iter", iter_cnt, 0);
    // A start raised during DONE is ignored; the one held into IDLE is accepted.
    start = 1'b1; num_iter = 4'd0;
    @(posedge clk); #1;
    chk("s1_start_in_done_busy", busy, 0);
    @(posedge clk); #1;
    chk("s1_restart_busy", busy, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("s1_restart_done", done, 1);
    check_amps(1'b0, "s1_amp", -1, 23, 23);

    // Scenario 2: one iteration, target 5
    run(1'b0, 5, 1, 0, cyc);
    chk("s2_cyc", cyc, 20);
    chk("s2_iter", iter_cnt, 1);
    @(posedge clk); #1;
    chk("s2_busy_after", busy, 0);
    chk("s2_done_after", done, 0);
    check_amps(1'b0, "s2_amp", 5, 57, 11);

    // Scenario 3: two iterations, target 5
    run(1'b0, 5, 2, 0, cyc);
    chk("s3_cyc", cyc, 38);
    chk("s3_iter", iter_cnt, 2);
    check_amps(1'b0, "s3_amp", 5, 61, -7);

    // Scenario 4: saturation corners with INIT_AMP = -128
    run(1'b1, 0, 1, 0, cyc);
    chk("s4_cyc", cyc, 20);
    chk("s4_iter", iter_cnt_m, 1);
    check_amps(1'b1, "s4_amp", 0, -128, -66);

    // Scenario 5: mid-run start with changed operands is ignored
    d0 = done_cnt;
    run(1'b0, 5, 1, 5, cyc);
    chk("s5_cyc", cyc, 20);
    repeat (4) begin @(posedge clk); #1; end
    chk("s5_done_pulses", done_cnt - d0, 1);
    chk("s5_busy", busy, 0);
    chk("s5_iter", iter_cnt, 1);
    check_amps(1'b0, "s5_amp", 5, 57, 11);

    // Scenario 6: asynchronous reset during DIFF of iteration 2 of 3
    @(posedge clk); #1;
    start = 1'b1; target = 3'd1; num_iter = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    repeat (31) begin @(posedge clk); #1; cyc++; end
    chk("s6_pre_busy", busy, 1);
    chk("s6_pre_iter", iter_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    chk("s6_iter", iter_cnt, 0);
    check_amps(1'b0, "s6_rst_amp", -1, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    run(1'b0, 2, 1, 0, cyc);
    chk("s6_cyc", cyc, 20);
    chk("s6_iter_after", iter_cnt, 1);
    check_amps(1'b0, "s6_amp", 2, 57, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
